lifo_arbiter: RTL and testbench
===============================

LIFO_ARBITER -- requirements
Module: lifo_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requester ports, 2..16.
REQ-002 Parameter DATA_W, default 32: stack data width.
REQ-003 Parameter DEPTH, default 8: depth of attached stack, power of 2; informational, used for assertions only.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 nrst  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  N_REQ  per-port request pending.
REQ-007 req_push  input  N_REQ  per-port op: 1 = push, 0 = pop.
REQ-008 req_lock  input  N_REQ  per-port request to hold exclusive ownership after this transaction.
REQ-009 req_data  input  N_REQ x DATA_W  per-port push data.
REQ-010 req_ready  output  N_REQ  one-hot grant; handshake = req_valid[i] && req_ready[i].
REQ-011 rsp_valid  output  N_REQ  one-cycle pulse on the port whose request completed.
REQ-012 rsp_err  output  1  qualifies rsp_valid: overflow (push when full) or underflow (pop when empty).
REQ-013 rsp_data  output  DATA_W  popped word; 0 for push or error responses.
REQ-014 lf_w_req, lf_r_req  output  1 each  write/read strobes to the stack.
REQ-015 lf_w_data  output  DATA_W  write data to the stack.
REQ-016 lf_r_data  input  DATA_W  stack top, FWFT mode (valid combinationally while not empty).
REQ-017 lf_empty, lf_full  input  1 each  stack status.
REQ-018 locked  output  1  high while in LOCKED state; lock_owner  output  $clog2(N_REQ)  current owner index.

Function
REQ-019 At most one request SHALL be granted per cycle; throughput is one transaction per cycle.
REQ-020 req_ready SHALL be combinational from req_valid, state and the round-robin pointer; req_ready is never asserted on a port with req_valid low.
REQ-021 In IDLE, the grant SHALL go to the first valid port searching from (last_grant+1) mod N_REQ upward, with wrap-around.
REQ-022 last_grant SHALL update only on a handshake.
REQ-023 A granted push with lf_full low SHALL assert lf_w_req and drive lf_w_data = req_data of that port in the same cycle.
REQ-024 A granted pop with lf_empty low SHALL assert lf_r_req in the same cycle and register lf_r_data.
REQ-025 A granted push with lf_full high, or pop with lf_empty high, SHALL be consumed without strobing the stack and SHALL respond with rsp_err = 1.
REQ-026 Each handshake SHALL produce exactly one rsp_valid pulse on the granted port one cycle later (latency 1), with rsp_err/rsp_data registered alongside.
REQ-027 lf_w_req and lf_r_req SHALL never be asserted in the same cycle.
REQ-028 State machine: IDLE and LOCKED.
REQ-029 IDLE->LOCKED on a handshake with req_lock = 1; owner := granted port.
REQ-030 In LOCKED, only the owner SHALL be granted; other ports stall regardless of the pointer.
REQ-031 LOCKED->IDLE on an owner handshake with req_lock = 0; that transaction completes normally.
REQ-032 An owner error response SHALL NOT release the lock.
REQ-033 When owner req_valid is low, LOCKED SHALL be held with no grant (no timeout).
REQ-034 rsp_err and rsp_data SHALL be 0 in any cycle where rsp_valid is all-zero.

Reset
REQ-035 While nrst is low, the block SHALL be in IDLE and every output SHALL be 0: req_ready, rsp_valid, rsp_err, rsp_data, lf_w_req, lf_r_req, lf_w_data, locked, lock_owner.
REQ-036 Reset SHALL set last_grant = N_REQ-1, so port 0 has first priority.
REQ-037 Reset asserted mid-lock or mid-response SHALL drop the lock and any pending rsp_valid; no response is delivered for the interrupted transaction.

Structure
REQ-038 The shared package SHALL hold the state enum (IDLE, LOCKED) and the response-type encoding; nothing else.
REQ-039 Round-robin selection SHALL be one sub-module, rr_pick (inputs request mask and pointer; outputs one-hot grant and index), instantiated once.
REQ-040 The stack itself SHALL be external; this block contains no storage beyond the state, pointer and response registers.

Verification
REQ-041 Ports 0..3 all push continuously from reset, with data 0xA0..0xA3 -> grants 0,1,2,3,0 on consecutive cycles; no error.
REQ-042 Empty stack, port 2 pops -> rsp_valid[2] pulses the next cycle with rsp_err = 1 and rsp_data = 0; lf_r_req stays 0.
REQ-043 Port 1 pushes 0x11 then pops -> pop response has rsp_data = 0x11, rsp_err = 0.
REQ-044 Port 3 pushes with req_lock = 1 while ports 0..2 stay valid -> only port 3 is granted; after its req_lock = 0 transaction, the next grant goes to port 0.
REQ-045 DEPTH = 8 full stack, port 0 pushes -> rsp_err = 1, lf_w_req = 0, and stack contents are unchanged.
REQ-046 nrst pulsed low while LOCKED with a pending response -> locked = 0 and rsp_valid = 0 immediately; the first grant after release goes to port 0.

Source files
------------

// File: rtl/lifo_arbiter_pkg.sv
// Shared types for the LIFO arbiter: controller state and the
// classification of the response being returned to a requester.
package lifo_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_OK   = 2'd1,
        RSP_OVF  = 2'd2,
        RSP_UDF  = 2'd3
    } rsp_e;

endpackage

// File: rtl/lifo_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req_mask_i strictly after ptr_i,
// wrapping at N_REQ, returned as a one-hot grant and its index.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_mask_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            // ptr + k never exceeds 2*N_REQ-1, so a single subtract wraps it
            sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!any_o && req_mask_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Arbitrates N_REQ push/pop requesters onto one external FWFT stack with
// round-robin fairness, an exclusive lock mode and 1-cycle responses.
module lifo_arbiter
    import lifo_arbiter_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 8,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0]              req_push,
    input  logic [N_REQ-1:0]              req_lock,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic                          rsp_err,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          lf_w_req,
    output logic                          lf_r_req,
    output logic [DATA_W-1:0]             lf_w_data,
    input  logic [DATA_W-1:0]             lf_r_data,
    input  logic                          lf_empty,
    input  logic                          lf_full,
    output logic                          locked,
    output logic [IDX_W-1:0]              lock_owner
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [N_REQ-1:0]  rsp_vld_q, rsp_vld_d;
    rsp_e              rsp_type_q, rsp_type_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [N_REQ-1:0]  owner_oh, cand, gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any, hs, op_push, ovf, udf;

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // Reset gates the request mask so every combinational output is low in reset
    assign cand = ((state_q == ST_LOCKED) ? (req_valid & owner_oh) : req_valid)
                  & {N_REQ{nrst}};

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_mask_i (cand),
        .ptr_i      (last_q),
        .gnt_o      (gnt),
        .idx_o      (gnt_idx),
        .any_o      (gnt_any)
    );

    assign hs        = gnt_any;
    assign req_ready = gnt;
    assign op_push   = req_push[gnt_idx];
    assign ovf       = hs &  op_push & lf_full;
    assign udf       = hs & ~op_push & lf_empty;
    assign lf_w_req  = hs &  op_push & ~lf_full;
    assign lf_r_req  = hs & ~op_push & ~lf_empty;
    assign lf_w_data = lf_w_req ? req_data[gnt_idx] : '0;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        rsp_vld_d  = '0;
        rsp_type_d = RSP_NONE;
        rsp_data_d = '0;
        if (hs) begin
            last_d     = gnt_idx;
            rsp_vld_d  = gnt;
            rsp_type_d = ovf ? RSP_OVF : (udf ? RSP_UDF : RSP_OK);
            if (lf_r_req) begin
                rsp_data_d = lf_r_data;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (req_lock[gnt_idx]) begin
                        state_d = ST_LOCKED;
                        owner_d = gnt_idx;
                    end
                end
                ST_LOCKED: begin
                    // A failed owner transaction keeps the lock so it can retry
                    if (!req_lock[gnt_idx] && !ovf && !udf) begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            last_q     <= IDX_W'(N_REQ - 1);
            owner_q    <= '0;
            rsp_vld_q  <= '0;
            rsp_type_q <= RSP_NONE;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_type_q <= rsp_type_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid  = rsp_vld_q;
    assign rsp_err    = (rsp_type_q == RSP_OVF) || (rsp_type_q == RSP_UDF);
    assign rsp_data   = rsp_data_q;
    assign locked     = (state_q == ST_LOCKED);
    assign lock_owner = owner_q;

    a_depth_pow2: assert property (@(posedge clk)
        (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
    a_no_dual_strobe: assert property (@(posedge clk) disable iff (!nrst)
        !(lf_w_req && lf_r_req));
    a_grant_onehot: assert property (@(posedge clk) disable iff (!nrst)
        $onehot0(req_ready) && ((req_ready & ~req_valid) == '0));

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter with a behavioural 8-deep FWFT stack attached.
module tb_lifo_arbiter;

    logic             clk;
    logic             nrst;
    logic [3:0]       req_valid, req_push, req_lock;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_ready, rsp_valid;
    logic             rsp_err, lf_w_req, lf_r_req, lf_empty, lf_full, locked;
    logic [31:0]      rsp_data, lf_w_data, lf_r_data;
    logic [1:0]       lock_owner;

    int checks = 0;
    int errors = 0;

    lifo_arbiter #(.N_REQ(4), .DATA_W(32), .DEPTH(8)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_valid  (req_valid),
        .req_push   (req_push),
        .req_lock   (req_lock),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data),
        .lf_w_req   (lf_w_req),
        .lf_r_req   (lf_r_req),
        .lf_w_data  (lf_w_data),
        .lf_r_data  (lf_r_data),
        .lf_empty   (lf_empty),
        .lf_full    (lf_full),
        .locked     (locked),
        .lock_owner (lock_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External stack model
    logic [31:0] mem [8];
    int          cnt;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) cnt <= 0;
        else if (lf_w_req) begin
            if (cnt >= 0 && cnt < 8) mem[cnt] <= lf_w_data;
            cnt <= cnt + 1;
        end else if (lf_r_req) cnt <= cnt - 1;
    end
    assign lf_empty  = (cnt <= 0);
    assign lf_full   = (cnt >= 8);
    assign lf_r_data = (cnt > 0 && cnt <= 8) ? mem[cnt-1] : 32'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_push  = '0;
        req_lock  = '0;
        req_data  = '0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        idle_inputs();
        step();
        step();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        idle_inputs();
        step();
        req_valid = 4'hF;
        req_push  = 4'hF;
        req_data[0] = 32'h5A5A5A5A;
        #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %h exp 0", req_ready); end
        checks++; if (lf_w_req !== 1'b0) begin errors++; $display("FAIL reset_wreq got %b exp 0", lf_w_req); end
        checks++; if (lf_w_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", lf_w_data); end
        step();
        checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL reset_rspv got %h exp 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0 || rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp err %b data %h exp 0", rsp_err, rsp_data); end
        checks++; if (locked !== 1'b0 || lock_owner !== 2'd0) begin errors++; $display("FAIL reset_lock locked %b owner %0d exp 0", locked, lock_owner); end
        checks++; if (lf_r_req !== 1'b0) begin errors++; $display("FAIL reset_rreq got %b exp 0", lf_r_req); end
        idle_inputs();
    endtask

    task automatic test_rr_push();
        logic [3:0] exp;
        do_reset();
        req_valid = 4'hF;
        req_push  = 4'hF;
        for (int p = 0; p < 4; p++) req_data[p] = 32'hA0 + p;
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            #1;
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_grant%0d got %h exp %h", k, req_ready, exp); end
            checks++; if (lf_w_req !== 1'b1 || lf_w_data !== 32'hA0 + (k % 4)) begin errors++; $display("FAIL rr_wr%0d wreq %b data %h exp 1 %h", k, lf_w_req, lf_w_data, 32'hA0 + (k % 4)); end
            step();
            checks++; if (rsp_valid !== exp || rsp_err !== 1'b0) begin errors++; $display("FAIL rr_rsp%0d got %h err %b exp %h err 0", k, rsp_valid, rsp_err, exp); end
        end
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rr_noreq_ready got %h exp 0", req_ready); end
        step();
        checks++; if (rsp_valid !== 4'h0 || rsp_err !== 1'b0 || rsp_data !== 32'h0) begin errors++; $display("FAIL rr_quiet got v %h e %b d %h exp 0", rsp_valid, rsp_err, rsp_data); end
    endtask

    task automatic test_underflow();
        do_reset();
        req_valid = 4'b0100;
        req_push  = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL udf_ready got %h exp 4", req_ready); end
        checks++; if (lf_r_req !== 1'b0) begin errors++; $display("FAIL udf_rreq got %b exp 0", lf_r_req); end
        step();
        req_valid = '0;
        checks++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL udf_rsp got v %h e %b d %h exp 4 1 0", rsp_valid, rsp_err, rsp_data); end
        step();
        checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL udf_single_pulse got %h exp 0", rsp_valid); end
    endtask

    task automatic test_push_pop();
        do_reset();
        req_valid   = 4'b0010;
        req_push    = 4'b0010;
        req_data[1] = 32'h11;
        #1;
        checks++; if (req_ready !== 4'b0010 || lf_w_req !== 1'b1 || lf_w_data !== 32'h11) begin errors++; $display("FAIL pp_push rdy %h wreq %b d %h exp 2 1 11", req_ready, lf_w_req, lf_w_data); end
        step();
        req_push = 4'b0000;
        checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_data !== 32'h0) begin errors++; $display("FAIL pp_push_rsp v %h e %b d %h exp 2 0 0", rsp_valid, rsp_err, rsp_data); end
        #1;
        checks++; if (lf_r_req !== 1'b1 || lf_w_req !== 1'b0) begin errors++; $display("FAIL pp_pop_strobe rreq %b wreq %b exp 1 0", lf_r_req, lf_w_req); end
        step();
        req_valid = '0;
        checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_data !== 32'h11) begin errors++; $display("FAIL pp_pop_rsp v %h e %b d %h exp 2 0 11", rsp_valid, rsp_err, rsp_data); end
    endtask

    task automatic test_lock();
        do_reset();
        req_push    = 4'hF;
        req_valid   = 4'b1000;
        req_lock    = 4'b1000;
        req_data[3] = 32'h33;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lk_first got %h exp 8", req_ready); end
        step();
        checks++; if (locked !== 1'b1 || lock_owner !== 2'd3) begin errors++; $display("FAIL lk_enter locked %b owner %0d exp 1 3", locked, lock_owner); end
        req_valid = 4'hF;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lk_hold%0d got %h exp 8", k, req_ready); end
            step();
        end
        req_valid = 4'b0111;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL lk_owner_idle got %h exp 0", req_ready); end
        step();
        checks++; if (locked !== 1'b1 || rsp_valid !== 4'h0) begin errors++; $display("FAIL lk_stay locked %b rspv %h exp 1 0", locked, rsp_valid); end
        req_valid = 4'hF;
        req_lock  = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lk_release_gnt got %h exp 8", req_ready); end
        step();
        checks++; if (locked !== 1'b0 || rsp_valid !== 4'b1000) begin errors++; $display("FAIL lk_release locked %b rspv %h exp 0 8", locked, rsp_valid); end
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lk_after got %h exp 1", req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_overflow();
        do_reset();
        req_valid = 4'b0001;
        req_push  = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            req_data[0] = 32'hD0 + k;
            req_lock    = (k == 7) ? 4'b0001 : 4'b0000;
            #1;
            checks++; if (lf_w_req !== 1'b1) begin errors++; $display("FAIL ovf_fill%0d wreq %b exp 1", k, lf_w_req); end
            step();
        end
        checks++; if (locked !== 1'b1 || lf_full !== 1'b1) begin errors++; $display("FAIL ovf_pre locked %b full %b exp 1 1", locked, lf_full); end
        req_data[0] = 32'hEE;
        req_lock    = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b0001 || lf_w_req !== 1'b0) begin errors++; $display("FAIL ovf_strobe rdy %h wreq %b exp 1 0", req_ready, lf_w_req); end
        step();
        checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL ovf_rsp v %h e %b d %h exp 1 1 0", rsp_valid, rsp_err, rsp_data); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ovf_keeps_lock got %b exp 1", locked); end
        checks++; if (cnt !== 8 || lf_r_data !== 32'hD7) begin errors++; $display("FAIL ovf_contents cnt %0d top %h exp 8 d7", cnt, lf_r_data); end
        req_push = 4'b0000;
        #1;
        checks++; if (lf_r_req !== 1'b1) begin errors++; $display("FAIL ovf_pop_rreq got %b exp 1", lf_r_req); end
        step();
        req_valid = '0;
        checks++; if (rsp_data !== 32'hD7 || rsp_err !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL ovf_pop_rsp d %h e %b locked %b exp d7 0 0", rsp_data, rsp_err, locked); end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        req_valid = 4'b0100;
        req_push  = 4'hF;
        req_lock  = 4'b0100;
        step();
        checks++; if (locked !== 1'b1 || rsp_valid !== 4'b0100) begin errors++; $display("FAIL mr_pre locked %b rspv %h exp 1 4", locked, rsp_valid); end
        nrst = 1'b0;
        #1;
        checks++; if (locked !== 1'b0 || rsp_valid !== 4'h0 || req_ready !== 4'h0) begin errors++; $display("FAIL mr_async locked %b rspv %h rdy %h exp 0 0 0", locked, rsp_valid, req_ready); end
        step();
        nrst      = 1'b1;
        req_valid = 4'hF;
        req_lock  = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mr_first got %h exp 1", req_ready); end
        step();
        req_valid = '0;
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL mr_rsp got %h exp 1", rsp_valid); end
    endtask

    initial begin
        idle_inputs();
        nrst = 1'b0;
        test_reset();
        test_rr_push();
        test_underflow();
        test_push_pop();
        test_lock();
        test_overflow();
        test_reset_mid_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
